load_store_queue: RTL

Parametrised in-order load/store queue sitting between the dispatcher, the CDB, the RoB and the memory controller.
- Same role as the existing LSB, but depth and widths are generic.
- Commit is tracked per store entry, so a mispredict flush squashes only uncommitted entries; committed stores still drain to memory.
- Operand snooping is fully registered, and squashed in-flight loads are retired without broadcasting.

---
 rtl/load_store_queue.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_queue.sv
// load_store_queue: parametrised in-order load/store queue between dispatch,
// CDB, RoB and the memory controller. One outstanding memory request, issued
// from the head only. Stores are committed per entry so a flush keeps the
// committed prefix draining to memory while squashing everything younger.
// Optional build macro: LSB_IO_SAFE_EN (IO loads wait until they are the RoB head).
module load_store_queue #(
  parameter int unsigned LSB_WIDTH  = 3,
  parameter int unsigned RoB_WIDTH  = 8,
  parameter logic [1:0]  IO_BASE_HI = 2'b11
) (
  input  logic                 Sys_clk,
  input  logic                 Sys_rst,
  input  logic                 Sys_rdy,
  input  logic                 DPLSB_en,
  input  logic [6:0]           DPLSB_opcode,
  input  logic [RoB_WIDTH:0]   DPLSB_Qj,
  input  logic [RoB_WIDTH:0]   DPLSB_Qk,
  input  logic [31:0]          DPLSB_Vj,
  input  logic [31:0]          DPLSB_Vk,
  input  logic [31:0]          DPLSB_imm,
  input  logic [RoB_WIDTH-1:0] DPLSB_RoB_index,
  output logic                 LSBDP_full,
  input  logic                 CDBLSB_en,
  input  logic [RoB_WIDTH-1:0] CDBLSB_RoB_index,
  input  logic [31:0]          CDBLSB_value,
  input  logic                 RoBLSB_commit_en,
  input  logic [RoB_WIDTH-1:0] RoBLSB_commit_index,
  input  logic [RoB_WIDTH-1:0] RoBLSB_head_index,
  input  logic                 RoBLSB_flush,
  output logic                 LSBMC_en,
  output logic                 LSBMC_wr,
  output logic [2:0]           LSBMC_data_width,
  output logic [31:0]          LSBMC_addr,
  output logic [31:0]          LSBMC_data,
  input  logic                 MCLSB_done,
  input  logic [31:0]          MCLSB_data,
  output logic                 LSBCDB_en,
  output logic [RoB_WIDTH-1:0] LSBCDB_RoB_index,
  output logic [31:0]          LSBCDB_value,
  output logic                 LSBRoB_store_en,
  output logic [RoB_WIDTH-1:0] LSBRoB_store_index
);
  localparam int unsigned DEPTH = 1 << LSB_WIDTH;
  localparam int unsigned CNT_W = LSB_WIDTH + 1;
  localparam int unsigned TAG_W = RoB_WIDTH + 1;
  localparam logic [TAG_W-1:0] NON_DEP = {1'b1, {RoB_WIDTH{1'b0}}};

  localparam logic [6:0] OP_LB  = 7'd11;
  localparam logic [6:0] OP_LH  = 7'd12;
  localparam logic [6:0] OP_LW  = 7'd13;
  localparam logic [6:0] OP_LBU = 7'd14;
  localparam logic [6:0] OP_LHU = 7'd15;
  localparam logic [6:0] OP_SB  = 7'd16;
  localparam logic [6:0] OP_SH  = 7'd17;
  localparam logic [6:0] OP_SW  = 7'd18;

  function automatic logic f_is_store(input logic [6:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [2:0] f_width(input logic [6:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 3'd1;
      OP_LH, OP_LHU, OP_SH: return 3'd2;
      default:              return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] f_load_ext(input logic [6:0] op, input logic [31:0] d);
    case (op)
      OP_LB:   return {{24{d[7]}}, d[7:0]};
      OP_LBU:  return {24'd0, d[7:0]};
      OP_LH:   return {{16{d[15]}}, d[15:0]};
      OP_LHU:  return {16'd0, d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] f_store_data(input logic [6:0] op, input logic [31:0] v);
    case (op)
      OP_SB:   return {24'd0, v[7:0]};
      OP_SH:   return {16'd0, v[15:0]};
      default: return v;
    endcase
  endfunction

  // Queue storage
  logic [DEPTH-1:0]     r_busy, r_committed, r_killed;
  logic [6:0]           r_op  [DEPTH];
  logic [TAG_W-1:0]     r_qj  [DEPTH];
  logic [TAG_W-1:0]     r_qk  [DEPTH];
  logic [31:0]          r_vj  [DEPTH];
  logic [31:0]          r_vk  [DEPTH];
  logic [31:0]          r_imm [DEPTH];
  logic [RoB_WIDTH-1:0] r_rob [DEPTH];
  logic [LSB_WIDTH-1:0] r_front, r_rear;
  logic [CNT_W-1:0]     r_count;
  logic                 r_inflight;

  logic [DEPTH-1:0]     w_commit_hit, w_commit_eff, w_drop;
  logic [CNT_W-1:0]     w_prefix, w_keep;
  logic                 w_run;
  logic [LSB_WIDTH-1:0] w_idx, w_off;
  logic [31:0]          w_addr;
  logic                 w_head_load, w_head_ready, w_io_ok, w_issue, w_done, w_push;
  logic [TAG_W-1:0]     w_dp_qj, w_dp_qk;
  logic [31:0]          w_dp_vj, w_dp_vk;

  assign LSBDP_full   = (r_count == CNT_W'(DEPTH));
  assign w_addr       = r_vj[r_front] + r_imm[r_front];
  assign w_head_load  = !f_is_store(r_op[r_front]);
  assign w_head_ready = r_busy[r_front] && r_qj[r_front][TAG_W-1] && r_qk[r_front][TAG_W-1];

`ifdef LSB_IO_SAFE_EN
  assign w_io_ok = (w_addr[17:16] != IO_BASE_HI) || (r_rob[r_front] == RoBLSB_head_index);
`else
  logic w_unused_io;
  assign w_io_ok     = 1'b1;
  assign w_unused_io = ^{RoBLSB_head_index, IO_BASE_HI};
`endif

  assign w_issue = Sys_rdy && !RoBLSB_flush && !r_inflight && (r_count != '0) && w_head_ready &&
                   (w_head_load ? w_io_ok : r_committed[r_front]);
  assign w_done  = Sys_rdy && r_inflight && MCLSB_done;
  assign w_push  = Sys_rdy && DPLSB_en && !LSBDP_full && !RoBLSB_flush;

  // Flush bookkeeping: same-cycle commits count, committed prefix survives
  always_comb begin
    w_commit_hit = '0;
    w_commit_eff = '0;
    w_drop       = '0;
    w_prefix     = '0;
    w_run        = 1'b1;
    w_idx        = '0;
    w_off        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_commit_hit[LSB_WIDTH'(i)] = RoBLSB_commit_en && r_busy[LSB_WIDTH'(i)] &&
                                    f_is_store(r_op[LSB_WIDTH'(i)]) &&
                                    (r_rob[LSB_WIDTH'(i)] == RoBLSB_commit_index);
      w_commit_eff[LSB_WIDTH'(i)] = r_committed[LSB_WIDTH'(i)] | w_commit_hit[LSB_WIDTH'(i)];
    end
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_front + LSB_WIDTH'(k);
      if (w_run && (CNT_W'(k) < r_count) && w_commit_eff[w_idx]) w_prefix = w_prefix + CNT_W'(1);
      else w_run = 1'b0;
    end
    w_keep = (r_inflight && w_head_load) ? CNT_W'(1) : w_prefix;
    for (int i = 0; i < DEPTH; i++) begin
      w_off = LSB_WIDTH'(i) - r_front;
      w_drop[LSB_WIDTH'(i)] = (CNT_W'(w_off) >= w_keep);
    end
  end

  // Dispatch bypass from this cycle's broadcasts
  always_comb begin
    w_dp_qj = DPLSB_Qj;
    w_dp_vj = DPLSB_Vj;
    w_dp_qk = DPLSB_Qk;
    w_dp_vk = DPLSB_Vk;
    if (CDBLSB_en && DPLSB_Qj == {1'b0, CDBLSB_RoB_index}) begin
      w_dp_qj = NON_DEP; w_dp_vj = CDBLSB_value;
    end else if (LSBCDB_en && DPLSB_Qj == {1'b0, LSBCDB_RoB_index}) begin
      w_dp_qj = NON_DEP; w_dp_vj = LSBCDB_value;
    end
    if (CDBLSB_en && DPLSB_Qk == {1'b0, CDBLSB_RoB_index}) begin
      w_dp_qk = NON_DEP; w_dp_vk = CDBLSB_value;
    end else if (LSBCDB_en && DPLSB_Qk == {1'b0, LSBCDB_RoB_index}) begin
      w_dp_qk = NON_DEP; w_dp_vk = LSBCDB_value;
    end
  end

  // Entry payload: dispatch write and registered operand snooping
  always_ff @(posedge Sys_clk) begin
    if (Sys_rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_busy[LSB_WIDTH'(i)]) begin
          if (CDBLSB_en && r_qj[LSB_WIDTH'(i)] == {1'b0, CDBLSB_RoB_index}) begin
            r_qj[LSB_WIDTH'(i)] <= NON_DEP; r_vj[LSB_WIDTH'(i)] <= CDBLSB_value;
          end else if (LSBCDB_en && r_qj[LSB_WIDTH'(i)] == {1'b0, LSBCDB_RoB_index}) begin
            r_qj[LSB_WIDTH'(i)] <= NON_DEP; r_vj[LSB_WIDTH'(i)] <= LSBCDB_value;
          end
          if (CDBLSB_en && r_qk[LSB_WIDTH'(i)] == {1'b0, CDBLSB_RoB_index}) begin
            r_qk[LSB_WIDTH'(i)] <= NON_DEP; r_vk[LSB_WIDTH'(i)] <= CDBLSB_value;
          end else if (LSBCDB_en && r_qk[LSB_WIDTH'(i)] == {1'b0, LSBCDB_RoB_index}) begin
            r_qk[LSB_WIDTH'(i)] <= NON_DEP; r_vk[LSB_WIDTH'(i)] <= LSBCDB_value;
          end
        end
      end
      if (w_push) begin
        r_op[r_rear]  <= DPLSB_opcode;
        r_qj[r_rear]  <= w_dp_qj;
        r_qk[r_rear]  <= w_dp_qk;
        r_vj[r_rear]  <= w_dp_vj;
        r_vk[r_rear]  <= w_dp_vk;
        r_imm[r_rear] <= DPLSB_imm;
        r_rob[r_rear] <= DPLSB_RoB_index;
      end
    end
  end

  // Control: pointers, flags, memory handshake and result pulses
  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      r_front <= '0; r_rear <= '0; r_count <= '0; r_inflight <= 1'b0;
      r_busy <= '0; r_committed <= '0; r_killed <= '0;
      LSBMC_en <= 1'b0; LSBMC_wr <= 1'b0; LSBMC_data_width <= '0;
      LSBMC_addr <= '0; LSBMC_data <= '0;
      LSBCDB_en <= 1'b0; LSBCDB_RoB_index <= '0; LSBCDB_value <= '0;
      LSBRoB_store_en <= 1'b0; LSBRoB_store_index <= '0;
    end else if (Sys_rdy) begin
      LSBCDB_en       <= 1'b0;
      LSBRoB_store_en <= 1'b0;
      r_committed     <= r_committed | w_commit_hit;
      if (w_issue) begin
        r_inflight       <= 1'b1;
        LSBMC_en         <= 1'b1;
        LSBMC_wr         <= !w_head_load;
        LSBMC_data_width <= f_width(r_op[r_front]);
        LSBMC_addr       <= w_addr;
        LSBMC_data       <= f_store_data(r_op[r_front], r_vk[r_front]);
      end
      if (w_done) begin
        r_inflight             <= 1'b0;
        LSBMC_en               <= 1'b0;
        r_busy[r_front]        <= 1'b0;
        r_committed[r_front]   <= 1'b0;
        r_killed[r_front]      <= 1'b0;
        r_front                <= r_front + LSB_WIDTH'(1);
        if (w_head_load && !r_killed[r_front] && !RoBLSB_flush) begin
          LSBCDB_en        <= 1'b1;
          LSBCDB_RoB_index <= r_rob[r_front];
          LSBCDB_value     <= f_load_ext(r_op[r_front], MCLSB_data);
        end
        if (!w_head_load) begin
          LSBRoB_store_en    <= 1'b1;
          LSBRoB_store_index <= r_rob[r_front];
        end
      end
      if (w_push) begin
        r_busy[r_rear]      <= 1'b1;
        r_committed[r_rear] <= 1'b0;
        r_killed[r_rear]    <= 1'b0;
        r_rear              <= r_rear + LSB_WIDTH'(1);
      end
      if (w_push && !w_done)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_done) r_count <= r_count - CNT_W'(1);
      if (RoBLSB_flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (w_drop[LSB_WIDTH'(i)]) begin
            r_busy[LSB_WIDTH'(i)]      <= 1'b0;
            r_committed[LSB_WIDTH'(i)] <= 1'b0;
            r_killed[LSB_WIDTH'(i)]    <= 1'b0;
          end
        end
        if (r_inflight && w_head_load && !w_done) r_killed[r_front] <= 1'b1;
        r_rear  <= r_front + LSB_WIDTH'(w_keep);
        r_count <= w_keep - CNT_W'(w_done);
      end
    end
  end

endmodule
